viterbi_decoder: RTL

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-4 convolutional code (generators 12_o and 15_o) produced by the transmit-side encoder. It sits on the receive path after bit recovery and turns each received odd/even symbol pair back into one decoded audio bit. It uses 8-state add-compare-select with register-exchange survivor paths, so output latency is fixed.

---
 rtl/viterbi_decoder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - Hard-decision 8-state register-exchange Viterbi decoder (rate 1/2, K=4)
//
// Decodes the rate-1/2 constraint-length-4 code whose branch outputs are
// odd = u ^ S[1] and even = u ^ S[0] ^ S[2], with S = {u(n-3), u(n-2), u(n-1)}.
// Every accepted symbol runs a full add-compare-select, metric normalisation,
// survivor update and best-state decision, so decode latency is fixed.
//
// Ports:
//   clk              decoder clock, all state updates on its rising edge
//   reset_n          asynchronous active-low reset
//   decode_en        symbol strobe, the received pair is consumed when high
//   encoded_in_odd   received odd-position bit
//   encoded_in_even  received even-position bit
//   audio_out        decoded bit (registered)
//   decode_valid     one-cycle qualifier for audio_out (registered)

module viterbi_decoder #(
    parameter int TRACEBACK_DEPTH = 16,
    parameter int METRIC_W        = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic decode_en,
    input  logic encoded_in_odd,
    input  logic encoded_in_even,
    output logic audio_out,
    output logic decode_valid
);

    localparam int D  = TRACEBACK_DEPTH;
    localparam int CW = $clog2(D + 1);
    localparam logic [METRIC_W-1:0] PM_MAX  = '1;
    localparam logic [METRIC_W-1:0] PM_INIT = METRIC_W'(8);

    logic [METRIC_W-1:0] pm_q   [8];
    logic [METRIC_W-1:0] pm_d   [8];
    logic [D-1:0]        surv_q [8];
    logic [D-1:0]        surv_d [8];
    logic [CW-1:0]       fill_q;
    logic [CW-1:0]       fill_d;
    logic                audio_out_q;
    logic                audio_out_d;
    logic                decode_valid_q;
    logic                decode_valid_d;

    logic [METRIC_W-1:0] acs_pm   [8];
    logic [D-1:0]        acs_surv [8];
    logic [METRIC_W-1:0] min_pm;
    logic [2:0]          best_idx;

    // Hamming distance between the received pair and the pair the encoder
    // would emit leaving state p on input u.
    function automatic logic [1:0] branch_metric(
        input logic [2:0] p,
        input logic       u,
        input logic       rx_odd,
        input logic       rx_even
    );
        logic exp_odd;
        logic exp_even;
        exp_odd  = u ^ p[1];
        exp_even = u ^ p[0] ^ p[2];
        return {1'b0, exp_odd ^ rx_odd} + {1'b0, exp_even ^ rx_even};
    endfunction

    function automatic logic [METRIC_W-1:0] sat_add(
        input logic [METRIC_W-1:0] a,
        input logic [1:0]          b
    );
        logic [METRIC_W:0] sum;
        sum = {1'b0, a} + {{(METRIC_W - 1){1'b0}}, b};
        return sum[METRIC_W] ? PM_MAX : sum[METRIC_W-1:0];
    endfunction

    // One ACS unit per next state. Both predecessors share S'[2:1] as their
    // low bits and differ only in the bit that falls off the register.
    for (genvar g = 0; g < 8; g++) begin : g_acs
        localparam logic [2:0] NS = 3'(g);
        localparam logic [2:0] P0 = {1'b0, NS[2:1]};
        localparam logic [2:0] P1 = {1'b1, NS[2:1]};

        logic [1:0]          bm0;
        logic [1:0]          bm1;
        logic [METRIC_W-1:0] cand0;
        logic [METRIC_W-1:0] cand1;
        logic                take1;

        assign bm0   = branch_metric(P0, NS[0], encoded_in_odd, encoded_in_even);
        assign bm1   = branch_metric(P1, NS[0], encoded_in_odd, encoded_in_even);
        assign cand0 = sat_add(pm_q[P0], bm0);
        assign cand1 = sat_add(pm_q[P1], bm1);
        // Strict compare: P0 wins ties.
        assign take1 = cand1 < cand0;

        assign acs_pm[g]   = take1 ? cand1 : cand0;
        assign acs_surv[g] = {take1 ? surv_q[P1][D-2:0] : surv_q[P0][D-2:0], NS[0]};
    end

    // Minimum metric doubles as the best state; strict compare keeps the
    // lowest index on ties.
    always_comb begin
        min_pm   = acs_pm[0];
        best_idx = 3'd0;
        for (int s = 1; s < 8; s++) begin
            if (acs_pm[s] < min_pm) begin
                min_pm   = acs_pm[s];
                best_idx = 3'(s);
            end
        end
    end

    always_comb begin
        pm_d           = pm_q;
        surv_d         = surv_q;
        fill_d         = fill_q;
        audio_out_d    = audio_out_q;
        decode_valid_d = 1'b0;
        if (decode_en) begin
            for (int s = 0; s < 8; s++) begin
                pm_d[s] = acs_pm[s] - min_pm;
            end
            surv_d         = acs_surv;
            fill_d         = (fill_q == CW'(D)) ? fill_q : fill_q + CW'(1);
            decode_valid_d = (fill_q >= CW'(D - 1));
            audio_out_d    = acs_surv[best_idx][D-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Non-zero start metrics on states 1..7 pin the trellis to the
            // encoder's all-zero start state.
            pm_q[0] <= '0;
            for (int s = 1; s < 8; s++) begin
                pm_q[s] <= PM_INIT;
            end
            for (int s = 0; s < 8; s++) begin
                surv_q[s] <= '0;
            end
            fill_q         <= '0;
            audio_out_q    <= 1'b0;
            decode_valid_q <= 1'b0;
        end else begin
            pm_q           <= pm_d;
            surv_q         <= surv_d;
            fill_q         <= fill_d;
            audio_out_q    <= audio_out_d;
            decode_valid_q <= decode_valid_d;
        end
    end

    assign audio_out    = audio_out_q;
    assign decode_valid = decode_valid_q;

endmodule
